// File: rtl/display_sched_pkg.sv
// Shared types and widths for the per-frame display sequencer.
package display_sched_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    MAP_START,
    MAP_WAIT,
    AG_START,
    AG_WAIT
  } sched_state_e;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter; flags expiry once a wait stage has lasted TIMEOUT cycles.
module stage_watchdog #(
  parameter int TIMEOUT = 20000
) (
  input  logic clock_50,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = run && (count_q == LAST_COUNT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Frame sequencer: map drawer, then each character drawer in order, with a
// single registered VGA plot port granted to whichever drawer is running.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int NUM_AGENTS = 5,
  parameter int TIMEOUT    = 20000
) (
  input  logic                          clock_50,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          frame_tick,
  output logic                          map_start,
  input  logic                          map_done,
  input  logic                          map_plot,
  input  logic [COORD_W-1:0]            map_x,
  input  logic [COORD_W-1:0]            map_y,
  input  logic [COLOR_W-1:0]            map_color,
  output logic [NUM_AGENTS-1:0]         agent_start,
  input  logic [NUM_AGENTS-1:0]         agent_done,
  input  logic [NUM_AGENTS-1:0]         agent_plot,
  input  logic [COORD_W*NUM_AGENTS-1:0] agent_x,
  input  logic [COORD_W*NUM_AGENTS-1:0] agent_y,
  input  logic [COLOR_W*NUM_AGENTS-1:0] agent_color,
  output logic                          vga_plot,
  output logic [COORD_W-1:0]            vga_x,
  output logic [COORD_W-1:0]            vga_y,
  output logic [COLOR_W-1:0]            vga_color,
  output logic                          busy,
  output logic                          frame_done,
  output logic [7:0]                    overrun_count,
  output logic                          timeout_flag
);

  localparam int IDX_W = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AGENTS - 1);

  sched_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic frame_done_q, frame_done_d;
  logic timeout_q, timeout_d;
  logic [7:0] overrun_q, overrun_d;
  logic plot_q, plot_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic wd_expired;

  logic [COORD_W-1:0] ag_x [NUM_AGENTS];
  logic [COORD_W-1:0] ag_y [NUM_AGENTS];
  logic [COLOR_W-1:0] ag_color [NUM_AGENTS];

  for (genvar gi = 0; gi < NUM_AGENTS; gi++) begin : g_agent
    assign ag_x[gi]        = agent_x[COORD_W*gi +: COORD_W];
    assign ag_y[gi]        = agent_y[COORD_W*gi +: COORD_W];
    assign ag_color[gi]    = agent_color[COLOR_W*gi +: COLOR_W];
    assign agent_start[gi] = (state_q == AG_START) && (idx_q == IDX_W'(gi));
  end

  // Every WAIT state is entered from its START state, so START clears the count.
  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock_50 (clock_50),
    .reset    (reset),
    .clear    ((state_q == MAP_START) || (state_q == AG_START)),
    .run      ((state_q == MAP_WAIT) || (state_q == AG_WAIT)),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE:      if (frame_tick && en) state_d = MAP_START;
      MAP_START: state_d = MAP_WAIT;
      MAP_WAIT: begin
        if (map_done || wd_expired) begin
          idx_d   = '0;
          state_d = AG_START;
          if (!map_done) timeout_d = 1'b1;
        end
      end
      AG_START:  state_d = AG_WAIT;
      AG_WAIT: begin
        if (agent_done[idx_q] || wd_expired) begin
          if (!agent_done[idx_q]) timeout_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = AG_START;
          end
        end
      end
      default:   state_d = IDLE;
    endcase
    if (frame_tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  // Grant mux; the pixel accompanying done is still forwarded.
  always_comb begin
    plot_d  = 1'b0;
    x_d     = '0;
    y_d     = '0;
    color_d = '0;
    if (state_q == MAP_WAIT) begin
      plot_d  = map_plot;
      x_d     = map_x;
      y_d     = map_y;
      color_d = map_color;
    end else if (state_q == AG_WAIT) begin
      plot_d  = agent_plot[idx_q];
      x_d     = ag_x[idx_q];
      y_d     = ag_y[idx_q];
      color_d = ag_color[idx_q];
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= '0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
    end
  end

  assign map_start     = (state_q == MAP_START);
  assign busy          = (state_q != IDLE);
  assign frame_done    = frame_done_q;
  assign timeout_flag  = timeout_q;
  assign overrun_count = overrun_q;
  assign vga_plot      = plot_q;
  assign vga_x         = x_q;
  assign vga_y         = y_q;
  assign vga_color     = color_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: cycle table for one frame plus
// hand-written sequences for pixels, watchdog, overrun and mid-frame reset.
module tb_display_scheduler;

  localparam int NA = 5;
  localparam int TO = 16;

  logic clock_50 = 1'b0;
  logic reset, en, frame_tick;
  logic map_start, map_done, map_plot;
  logic [7:0] map_x, map_y;
  logic [2:0] map_color;
  logic [NA-1:0] agent_start, agent_done, agent_plot;
  logic [8*NA-1:0] agent_x, agent_y;
  logic [3*NA-1:0] agent_color;
  logic vga_plot;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_color;
  logic busy, frame_done, timeout_flag;
  logic [7:0] overrun_count;

  int checks = 0;
  int errors = 0;

  display_scheduler #(.NUM_AGENTS(NA), .TIMEOUT(TO)) dut (
    .clock_50(clock_50), .reset(reset), .en(en), .frame_tick(frame_tick),
    .map_start(map_start), .map_done(map_done), .map_plot(map_plot),
    .map_x(map_x), .map_y(map_y), .map_color(map_color),
    .agent_start(agent_start), .agent_done(agent_done), .agent_plot(agent_plot),
    .agent_x(agent_x), .agent_y(agent_y), .agent_color(agent_color),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .busy(busy), .frame_done(frame_done), .overrun_count(overrun_count),
    .timeout_flag(timeout_flag)
  );

  always #10 clock_50 = ~clock_50;

  wire [36:0] all_out = {map_start, agent_start, vga_plot, vga_x, vga_y, vga_color,
                         busy, frame_done, overrun_count, timeout_flag};

  typedef struct packed {
    logic       tick;
    logic       mdone;
    logic [4:0] adone;
    logic [7:0] exp;   // {map_start, agent_start[4:0], busy, frame_done}
  } vec_t;

  vec_t tbl [27];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock_50);
    #1;
  endtask

  task automatic clear_inputs();
    en = 1'b1; frame_tick = 1'b0; map_done = 1'b0; map_plot = 1'b0;
    map_x = '0; map_y = '0; map_color = '0;
    agent_done = '0; agent_plot = '0; agent_x = '0; agent_y = '0; agent_color = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    @(negedge clock_50);
    check("reset_outputs", 64'(all_out), 64'd0);
    next_cycle();
    reset = 1'b0;

    // Single frame table: each done three cycles after its start
    for (int r = 0; r < 27; r++) tbl[r] = '0;
    tbl[0].tick = 1'b1;
    tbl[1].exp  = 8'b1_00000_1_0;
    for (int r = 2; r < 5; r++) tbl[r].exp = 8'b0_00000_1_0;
    tbl[4].mdone = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tbl[5 + 4*i].exp = {1'b0, 5'(1 << i), 1'b1, 1'b0};
      for (int k = 1; k < 4; k++) tbl[5 + 4*i + k].exp = 8'b0_00000_1_0;
      tbl[8 + 4*i].adone = 5'(1 << i);
    end
    tbl[6].adone = 5'b00010;   // non-selected agent done, ignored
    tbl[7].mdone = 1'b1;       // map done outside MAP_WAIT, ignored
    tbl[10].adone = 5'b00001;  // stale done of agent 0 during agent 1
    tbl[25].exp  = 8'b0_00000_0_1;
    tbl[25].tick = 1'b1;       // tick in first IDLE cycle is accepted
    tbl[26].exp  = 8'b1_00000_1_0;

    for (int r = 0; r < 27; r++) begin
      frame_tick = tbl[r].tick;
      map_done   = tbl[r].mdone;
      agent_done = tbl[r].adone;
      @(negedge clock_50);
      check($sformatf("frame_row_%0d", r),
            64'({map_start, agent_start, busy, frame_done}), 64'(tbl[r].exp));
      next_cycle();
    end
    $display("seq frame table done");

    // Pixel forwarding and grant
    do_reset();
    frame_tick = 1'b1;
    next_cycle();                         // MAP_START
    frame_tick = 1'b0;
    next_cycle();                         // MAP_WAIT
    map_plot = 1'b1; map_x = 8'd10; map_y = 8'd20; map_color = 3'b001;
    agent_plot = '1; agent_x = {5{8'hAA}}; agent_y = {5{8'h55}}; agent_color = {5{3'b110}};
    next_cycle();                         // MAP_WAIT, done now
    map_plot = 1'b0; map_done = 1'b1;
    @(negedge clock_50);
    check("map_pixel", 64'({vga_plot, vga_x, vga_y, vga_color}), 64'({1'b1, 8'd10, 8'd20, 3'b001}));
    next_cycle();                         // AG_START
    map_done = 1'b0;
    @(negedge clock_50);
    check("map_plot_low", 64'(vga_plot), 64'd0);
    next_cycle();                         // AG_WAIT idx0
    agent_x = {{4{8'hAA}}, 8'd33}; agent_y = {{4{8'h55}}, 8'd44};
    agent_color = {{4{3'b110}}, 3'b101}; agent_done = 5'b00001;
    @(negedge clock_50);
    check("no_plot_in_start", 64'(vga_plot), 64'd0);
    next_cycle();                         // AG_START idx1
    agent_done = '0; agent_plot = '0;
    @(negedge clock_50);
    check("agent_pixel_with_done", 64'({vga_plot, vga_x, vga_y, vga_color}),
          64'({1'b1, 8'd33, 8'd44, 3'b101}));
    $display("seq pixel done");

    // Watchdog expiry on the map stage
    do_reset();
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    n = 0; seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock_50);
      if (agent_start == 5'b00001) begin
        seen = 1'b1;
        check("timeout_flag_set", 64'(timeout_flag), 64'd1);
      end else if (busy && !map_start) begin
        n++;
      end
      if (!seen) next_cycle();
    end
    check("watchdog_seen", 64'(seen), 64'd1);
    check("map_wait_cycles", 64'(n), 64'd16);
    agent_done = '1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      next_cycle();
      @(negedge clock_50);
      if (frame_done) seen = 1'b1;
    end
    check("timeout_frame_done", 64'(seen), 64'd1);
    check("timeout_flag_at_done", 64'({timeout_flag, busy}), 64'b10);
    next_cycle();
    agent_done = '0;
    @(negedge clock_50);
    check("timeout_flag_sticky", 64'(timeout_flag), 64'd1);
    $display("seq watchdog done");

    // Overrun counting, en gating and saturation
    do_reset();
    frame_tick = 1'b1;
    next_cycle();                         // MAP_START
    repeat (3) next_cycle();              // three ticks while busy
    frame_tick = 1'b0; map_done = 1'b1; agent_done = '1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock_50);
      if (frame_done) seen = 1'b1;
      next_cycle();
    end
    check("overrun_frame_done", 64'(seen), 64'd1);
    map_done = 1'b0; agent_done = '0;
    check("overrun_three", 64'(overrun_count), 64'd3);
    en = 1'b0; frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    @(negedge clock_50);
    check("en_low_ignored", 64'({map_start, busy, overrun_count}), 64'({2'b00, 8'd3}));
    next_cycle();
    en = 1'b1; frame_tick = 1'b1;
    repeat (400) next_cycle();
    frame_tick = 1'b0;
    @(negedge clock_50);
    check("overrun_saturate", 64'(overrun_count), 64'd255);
    $display("seq overrun done");

    // Reset during AG_WAIT of agent 2
    do_reset();
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0; map_done = 1'b1; agent_done = 5'b00011;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock_50);
      if (agent_start == 5'b00100) seen = 1'b1;
      next_cycle();
    end
    check("reached_agent2", 64'(seen), 64'd1);
    reset = 1'b1; agent_plot = 5'b00100; agent_x = {5{8'h77}};
    next_cycle();
    reset = 1'b0; agent_done = 5'b00100; map_done = 1'b0;
    @(negedge clock_50);
    check("midframe_reset_outputs", 64'(all_out), 64'd0);
    next_cycle();
    agent_done = '0; agent_plot = '0;
    @(negedge clock_50);
    check("stray_done_ignored", 64'({map_start, agent_start, busy, frame_done, vga_plot}), 64'd0);
    $display("seq midframe reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
